// File: rtl/spi_alu_responder.sv
// spi_alu_responder: captures an ALU request from the SPI receive stage,
// computes the result, and shifts the response word back to the master MSB
// first while CS is low.
// Optional feature macro: ALU_FLAGS_EN appends the {N,Z,C,V} flags to the
// response, which then grows from W to W+4 bits.
// Ports:
//   clk_arduino  SPI serial clock, all logic on its rising edge
//   reset        asynchronous active-low reset
//   frame_valid  one-cycle pulse, operands and opcode valid
//   operando_1   first operand (W bits)
//   operando_2   second operand (W bits)
//   operador     4-bit opcode
//   CS           active-low chip select from the master
//   MISO         serial response bit to the master
//   leds         last computed result
//   busy         high whenever the FSM is not idle
//   overrun      sticky, a frame arrived while the FSM was busy
module spi_alu_responder #(
    parameter int unsigned W = 4
) (
    input  logic         clk_arduino,
    input  logic         reset,
    input  logic         frame_valid,
    input  logic [W-1:0] operando_1,
    input  logic [W-1:0] operando_2,
    input  logic [3:0]   operador,
    input  logic         CS,
    output logic         MISO,
    output logic [W-1:0] leds,
    output logic         busy,
    output logic         overrun
);

`ifdef ALU_FLAGS_EN
    localparam int unsigned RESP_W = W + 4;
`else
    localparam int unsigned RESP_W = W;
`endif
    localparam int unsigned CNT_W = $clog2(RESP_W + 1);

    typedef enum logic [1:0] {IDLE, EXEC, READY, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       op1_q, op1_d, op2_q, op2_d;
    logic [3:0]         opc_q, opc_d;
    logic [W-1:0]       result_q, result_d;
    logic [W-1:0]       leds_d;
    logic               miso_d, busy_d, overrun_d;
    logic [W-1:0]       alu_res;
    logic [RESP_W-1:0]  resp_word, resp_shift;
    logic               resp_bit;

`ifdef ALU_FLAGS_EN
    logic [3:0]         flags_q, flags_d;
    logic [W:0]         sum_ext, diff_ext;
    logic               alu_c, alu_v;

    // Carry/borrow and signed overflow from the captured operands
    always_comb begin
        sum_ext  = {1'b0, op1_q} + {1'b0, op2_q};
        diff_ext = {1'b0, op1_q} - {1'b0, op2_q};
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (opc_q)
            4'b0000: begin
                alu_c = sum_ext[W];
                alu_v = (op1_q[W-1] == op2_q[W-1]) && (sum_ext[W-1] != op1_q[W-1]);
            end
            4'b0001: begin
                alu_c = diff_ext[W];
                alu_v = (op1_q[W-1] != op2_q[W-1]) && (diff_ext[W-1] != op1_q[W-1]);
            end
            4'b0101: alu_c = op1_q[W-1];
            4'b0110: alu_c = op1_q[0];
            default: ;
        endcase
    end

    assign resp_word = {result_q, flags_q};
`else
    assign resp_word = result_q;
`endif

    // Result datapath, truncated to W bits; undefined opcodes give zero
    always_comb begin
        alu_res = '0;
        case (opc_q)
            4'b0000: alu_res = op1_q + op2_q;
            4'b0001: alu_res = op1_q - op2_q;
            4'b0010: alu_res = op1_q & op2_q;
            4'b0011: alu_res = op1_q | op2_q;
            4'b0100: alu_res = op1_q ^ op2_q;
            4'b0101: alu_res = {op1_q[W-2:0], 1'b0};
            4'b0110: alu_res = {1'b0, op1_q[W-1:1]};
            4'b0111: alu_res = op1_q * op2_q;
            default: alu_res = '0;
        endcase
    end

    // Bit counter doubles as the index of the next response bit, MSB first
    assign resp_shift = resp_word << cnt_q;
    assign resp_bit   = resp_shift[RESP_W-1];

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opc_d     = opc_q;
        result_d  = result_q;
        leds_d    = leds;
        miso_d    = 1'b0;
        overrun_d = overrun | (frame_valid && (state_q != IDLE));
`ifdef ALU_FLAGS_EN
        flags_d   = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    op1_d   = operando_1;
                    op2_d   = operando_2;
                    opc_d   = operador;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_res;
                leds_d   = alu_res;
`ifdef ALU_FLAGS_EN
                flags_d  = {alu_res[W-1], (alu_res == '0), alu_c, alu_v};
`endif
                state_d  = READY;
            end
            READY: begin
                if (!CS) begin
                    miso_d  = resp_bit;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Completion wins over CS: the whole word has already gone out
                if (cnt_q == CNT_W'(RESP_W)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (CS) begin
                    cnt_d   = '0;
                    state_d = READY;
                end else begin
                    miso_d  = resp_bit;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_arduino or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            opc_q    <= '0;
            result_q <= '0;
            leds     <= '0;
            MISO     <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
`ifdef ALU_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            opc_q    <= opc_d;
            result_q <= result_d;
            leds     <= leds_d;
            MISO     <= miso_d;
            busy     <= busy_d;
            overrun  <= overrun_d;
`ifdef ALU_FLAGS_EN
            flags_q  <= flags_d;
`endif
        end
    end

endmodule
